wrr_rank_ctrl: RTL
==================

# wrr_rank_ctrl

Parametrised weighted round-robin rank computer for the PIFO rank pipeline. It assigns each inserted packet a rank so that flows are served in proportion to their weights, then buffers rank, metadata and flow ID in an internal fall-through FIFO until the PIFO pulls them. Compared with the first-generation WRR ranker it adds:
- configurable FIFO depth and flow count;
- per-flow occupancy tracking, so drained flows leave the round;
- a flow ID output;
- explicit drop and error reporting;
- saturating rank arithmetic.

## Interface
Parameters:
- FLOW_ID_WIDTH, 16, width of flow identifier
- FLOW_WEIGHT_WIDTH, 8, width of per-packet weight
- MAX_NUM_FLOWS, 16, number of tracked flows; flow IDs 0..MAX_NUM_FLOWS-1 are valid
- RANK_WIDTH, 16, rank width
- META_WIDTH, 16, opaque metadata width
- L2_DEPTH, 4, log2 of FIFO depth (DEPTH = 2^L2_DEPTH)

Ports (reset rst, synchronous, active-high; clock clk):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- insert  in  1  insert request, single-cycle per packet
- meta_in  in  META_WIDTH  packet metadata
- flowID_in  in  FLOW_ID_WIDTH  packet flow
- flow_weight_in  in  FLOW_WEIGHT_WIDTH  flow weight; 0 treated as 1
- busy  out  1  FIFO holds ≥ DEPTH-1 entries
- err_out  out  1  one-cycle pulse: insert dropped (bad flow ID or FIFO full)
- remove  in  1  pop head entry
- valid_out  out  1  FIFO non-empty
- rank_out  out  RANK_WIDTH  head rank
- meta_out  out  META_WIDTH  head metadata
- flowID_out  out  FLOW_ID_WIDTH  head flow ID

## Operation

Per-flow state:
- active bit
- last_rank (RANK_WIDTH)
- cnt (FLOW_WEIGHT_WIDTH)
- pkts (L2_DEPTH+1 bits)

Global state: max_rank, num_active (clog2(MAX_NUM_FLOWS+1) bits).

Accepted insert (flowID_in < MAX_NUM_FLOWS and FIFO not full), flow f, weight w = max(flow_weight_in, 1):
- Flow inactive:
  - rank = max_rank+1; cnt=1; active=1; num_active+1.
- Flow active, cnt ≥ w:
  - rank = last_rank + num_active; cnt=1.
- Flow active, otherwise:
  - rank = last_rank; cnt+1.
- Then last_rank=rank; max_rank=max(max_rank, rank); pkts+1.
- All additions saturate at 2^RANK_WIDTH-1, never wrap.

Rejected insert:
- No state change, no FIFO write.
- err_out=1 next cycle.

Remove:
- If valid_out=1: pop head; pkts[flowID_out] decrements.
- If valid_out=0: remove is ignored.

Deactivation (macro-controlled, see Configuration):
- When pkts reaches 0, clear active and decrement num_active.
- last_rank and cnt are kept but are unused until the next activation.

Simultaneous insert and remove:
- Both happen in the same cycle.
- Same flow: pkts unchanged and the flow stays active. The insert rank uses pre-update state.
- Different flows: both updates apply. If the remove deactivates a flow, num_active is net of both the insert-side activation and the remove-side deactivation.
- Insert while FIFO full but remove=1 in the same cycle: insert is still rejected; full is evaluated before the pop.

## Timing
- Reset values: busy=0, err_out=0, valid_out=0, rank_out/meta_out/flowID_out=0. All flow state, max_rank and num_active are 0.
- Rank is computed combinationally from registered state; state updates on the same clk edge as the FIFO write.
- Insert at cycle N into an empty FIFO: valid_out=1 and head outputs valid at N+1.
- Fall-through FIFO: head is visible without a read. remove at cycle N makes the next entry (or valid_out=0) visible at N+1.
- busy reflects occupancy after the current edge; inserts are accepted while busy=1 until the FIFO is full.
- err_out is registered: high exactly one cycle after the rejected insert.
- rst mid-operation flushes the FIFO and all state in one cycle. insert/remove in the reset cycle are ignored.

## Configuration
- WRR_FLOW_DEACTIVATE_EN defined:
  - A flow is deactivated when its pkts counter returns to 0.
  - Its next packet is treated as a new flow: rank = max_rank+1.
- Undefined:
  - Flows stay active from first insert until reset.
  - num_active only increments.
  - pkts counters still exist but do not affect active.

## Test plan
- MAX_NUM_FLOWS=4, no removes. Insert f0(w=2), f0(w=2), f1(w=1), f0(w=2), f1(w=1) → FIFO ranks 1,1,2,3,4; flowID_out 0,0,1,0,1.
- With WRR_FLOW_DEACTIVATE_EN defined:
  - Insert f2 (rank 1), remove it, then insert f2 again → rank 2, num_active=1.
  - Same sequence with the macro undefined → rank 1+1=2 via the active path, num_active=1 after the second insert.
- Insert flowID_in=7 with MAX_NUM_FLOWS=4 → err_out high one cycle later, valid_out stays 0, no state change.
- L2_DEPTH=4, 16 back-to-back inserts, no remove:
  - busy=1 after the 15th insert.
  - 17th insert dropped with err_out=1.
  - 16 removes return entries in insertion order.
- FIFO holding one f1 packet: insert f1 and remove in the same cycle → pkts[f1] stays 1, f1 remains active, next head is the new f1 entry with its computed rank.
- Force last_rank[f0]=0xFFFE, num_active=3, cnt ≥ w → rank_out=0xFFFF (saturated), max_rank=0xFFFF.
- Assert rst with 5 entries queued → valid_out=0 and busy=0 next cycle; a subsequent f0 insert gets rank 1.

Source files
------------

// File: rtl/wrr_rank_if.sv
// Insert/remove handshake bundle between a rank producer and the PIFO-side consumer.
// master drives requests and reads the FIFO head; slave is the rank controller.
interface wrr_rank_if #(
    parameter int unsigned FLOW_ID_WIDTH     = 16,
    parameter int unsigned FLOW_WEIGHT_WIDTH = 8,
    parameter int unsigned RANK_WIDTH        = 16,
    parameter int unsigned META_WIDTH        = 16
) ();
    logic                         insert;
    logic [META_WIDTH-1:0]        meta_in;
    logic [FLOW_ID_WIDTH-1:0]     flowID_in;
    logic [FLOW_WEIGHT_WIDTH-1:0] flow_weight_in;
    logic                         busy;
    logic                         err_out;
    logic                         remove;
    logic                         valid_out;
    logic [RANK_WIDTH-1:0]        rank_out;
    logic [META_WIDTH-1:0]        meta_out;
    logic [FLOW_ID_WIDTH-1:0]     flowID_out;

    modport master (
        output insert, meta_in, flowID_in, flow_weight_in, remove,
        input  busy, err_out, valid_out, rank_out, meta_out, flowID_out
    );

    modport slave (
        input  insert, meta_in, flowID_in, flow_weight_in, remove,
        output busy, err_out, valid_out, rank_out, meta_out, flowID_out
    );
endinterface

// File: rtl/wrr_rank_ctrl.sv
// Weighted round-robin rank computer feeding a fall-through FIFO of {rank, meta, flow ID}.
// Define WRR_FLOW_DEACTIVATE_EN to retire a flow once its queued packet count drains to zero.
module wrr_rank_ctrl #(
    parameter int unsigned FLOW_ID_WIDTH     = 16,
    parameter int unsigned FLOW_WEIGHT_WIDTH = 8,
    parameter int unsigned MAX_NUM_FLOWS     = 16,
    parameter int unsigned RANK_WIDTH        = 16,
    parameter int unsigned META_WIDTH        = 16,
    parameter int unsigned L2_DEPTH          = 4
) (
    input logic       clk,
    input logic       rst,
    wrr_rank_if.slave bus
);
    localparam int unsigned DEPTH  = 1 << L2_DEPTH;
    localparam int unsigned CNT_W  = L2_DEPTH + 1;
    localparam int unsigned SUM_W  = RANK_WIDTH + 1;
    localparam int unsigned FIDX_W = (MAX_NUM_FLOWS > 1) ? $clog2(MAX_NUM_FLOWS) : 1;
    localparam int unsigned NA_W   = $clog2(MAX_NUM_FLOWS + 1);

    logic [RANK_WIDTH-1:0]    rank_mem [DEPTH];
    logic [META_WIDTH-1:0]    meta_mem [DEPTH];
    logic [FLOW_ID_WIDTH-1:0] fid_mem  [DEPTH];
    logic [L2_DEPTH-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]         count_q;

    logic                         active_q    [MAX_NUM_FLOWS];
    logic [RANK_WIDTH-1:0]        last_rank_q [MAX_NUM_FLOWS];
    logic [FLOW_WEIGHT_WIDTH-1:0] cnt_q       [MAX_NUM_FLOWS];
    logic [CNT_W-1:0]             pkts_q      [MAX_NUM_FLOWS];
    logic [RANK_WIDTH-1:0]        max_rank_q, max_rank_d;
    logic [NA_W-1:0]              num_active_q, num_active_d;
    logic                         err_q;

    logic                         full, not_empty, id_ok, accept, pop;
    logic                         ins_new, ins_wrap, same_flow, deact;
    logic [FIDX_W-1:0]            fidx, hidx;
    logic [FLOW_WEIGHT_WIDTH-1:0] w_eff, cnt_next;
    logic [SUM_W-1:0]             sum_new, sum_act;
    logic [RANK_WIDTH-1:0]        new_rank;

    function automatic logic [RANK_WIDTH-1:0] sat(input logic [SUM_W-1:0] s);
        return s[RANK_WIDTH] ? {RANK_WIDTH{1'b1}} : s[RANK_WIDTH-1:0];
    endfunction

    always_comb begin
        full      = (count_q == CNT_W'(DEPTH));
        not_empty = (count_q != '0);
        fidx      = bus.flowID_in[FIDX_W-1:0];
        hidx      = fid_mem[rd_ptr_q][FIDX_W-1:0];
        id_ok     = (bus.flowID_in < FLOW_ID_WIDTH'(MAX_NUM_FLOWS));
        // Fullness is judged before any same-cycle pop.
        accept    = bus.insert && id_ok && !full;
        pop       = bus.remove && not_empty;
        w_eff     = (bus.flow_weight_in == '0) ? FLOW_WEIGHT_WIDTH'(1) : bus.flow_weight_in;
        ins_new   = !active_q[fidx];
        ins_wrap  = (cnt_q[fidx] >= w_eff);
        sum_new   = {1'b0, max_rank_q} + SUM_W'(1);
        sum_act   = {1'b0, last_rank_q[fidx]} + SUM_W'(num_active_q);

        if (ins_new) begin
            new_rank = sat(sum_new);
        end else if (ins_wrap) begin
            new_rank = sat(sum_act);
        end else begin
            new_rank = last_rank_q[fidx];
        end
        cnt_next   = (ins_new || ins_wrap) ? FLOW_WEIGHT_WIDTH'(1)
                                           : cnt_q[fidx] + FLOW_WEIGHT_WIDTH'(1);
        max_rank_d = (new_rank > max_rank_q) ? new_rank : max_rank_q;

        // An insert and a pop of the same flow cancel out in that flow's packet count.
        same_flow  = accept && pop && (fidx == hidx);
`ifdef WRR_FLOW_DEACTIVATE_EN
        deact      = pop && !same_flow && (pkts_q[hidx] == CNT_W'(1));
`else
        deact      = 1'b0;
`endif
        num_active_d = num_active_q + NA_W'(accept && ins_new) - NA_W'(deact);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            max_rank_q   <= '0;
            num_active_q <= '0;
            err_q        <= 1'b0;
            for (int unsigned i = 0; i < MAX_NUM_FLOWS; i++) begin
                active_q[i]    <= 1'b0;
                last_rank_q[i] <= '0;
                cnt_q[i]       <= '0;
                pkts_q[i]      <= '0;
            end
        end else begin
            err_q        <= bus.insert && !accept;
            count_q      <= count_q + CNT_W'(accept) - CNT_W'(pop);
            num_active_q <= num_active_d;
            if (accept) begin
                rank_mem[wr_ptr_q] <= new_rank;
                meta_mem[wr_ptr_q] <= bus.meta_in;
                fid_mem[wr_ptr_q]  <= bus.flowID_in;
                wr_ptr_q           <= wr_ptr_q + L2_DEPTH'(1);
                active_q[fidx]     <= 1'b1;
                last_rank_q[fidx]  <= new_rank;
                cnt_q[fidx]        <= cnt_next;
                max_rank_q         <= max_rank_d;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + L2_DEPTH'(1);
            end
            if (!same_flow) begin
                if (accept) begin
                    pkts_q[fidx] <= pkts_q[fidx] + CNT_W'(1);
                end
                if (pop) begin
                    pkts_q[hidx] <= pkts_q[hidx] - CNT_W'(1);
                end
            end
            if (deact) begin
                active_q[hidx] <= 1'b0;
            end
        end
    end

    assign bus.busy       = (count_q >= CNT_W'(DEPTH - 1));
    assign bus.err_out    = err_q;
    assign bus.valid_out  = not_empty;
    assign bus.rank_out   = not_empty ? rank_mem[rd_ptr_q] : '0;
    assign bus.meta_out   = not_empty ? meta_mem[rd_ptr_q] : '0;
    assign bus.flowID_out = not_empty ? fid_mem[rd_ptr_q] : '0;
endmodule
